mem_align_unit: RTL and testbench

MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

---
 rtl/mem_align_unit_pkg.sv | 27 ++
 rtl/mem_align_unit_if.sv | 34 +++
 rtl/mem_align_unit_lane_shift.sv | 61 ++++++
 rtl/mem_align_unit.sv | 142 ++++++++++++++
 tb/tb_mem_align_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_align_unit_pkg.sv
// Shared types for the memory alignment unit: funct3 size/sign codes and FSM states.
package mem_align_types;

  typedef enum logic [2:0] {
    F3_B    = 3'b000,
    F3_H    = 3'b001,
    F3_W    = 3'b010,
    F3_D    = 3'b011,
    F3_BU   = 3'b100,
    F3_HU   = 3'b101,
    F3_WU   = 3'b110,
    F3_RSVD = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_DONE
  } state_e;

  // Access size in bytes; funct3[2] only selects sign handling.
  function automatic logic [3:0] accessBytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// Request/response and memory-side bundle of the alignment unit; slave is the unit's view.
interface mem_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_byte_enable;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_align_unit_lane_shift.sv
// mem_lane_shift: combinational lane steering for store data, byte enables,
// load-byte alignment per beat, and final sign/zero extension of the held load.
module mem_lane_shift
  import mem_align_types::*;
#(
  parameter  int DATA_W = 32,
  localparam int B      = DATA_W / 8,
  localparam int LB     = $clog2(B)
) (
  input  logic [2:0]        i_funct3,
  input  logic [LB-1:0]     i_off,
  input  logic              i_beat1,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_hold,
  output logic [DATA_W-1:0] o_wdata,
  output logic [B-1:0]      o_byteEnable,
  output logic [DATA_W-1:0] o_rdataAligned,
  output logic [DATA_W-1:0] o_loadExt
);
  logic [3:0]      w_size;
  logic [2*B-1:0]  w_sizeMask;
  logic [2*B-1:0]  w_laneMask;
  logic [LB+3:0]   w_lowShift;
  logic [LB+3:0]   w_highShift;
  logic            w_signBit;

  assign w_size      = accessBytes(i_funct3);
  assign w_lowShift  = {1'b0, i_off, 3'b000};
  assign w_highShift = {(LB+1)'(B) - {1'b0, i_off}, 3'b000};

  always_comb begin
    w_sizeMask = '0;
    for (int i = 0; i < 2 * B; i++) begin
      w_sizeMask[i] = (i < int'(w_size));
    end
  end

  // The mask spans two words: low half lanes belong to beat 0, high half to beat 1.
  assign w_laneMask     = w_sizeMask << i_off;
  assign o_byteEnable   = i_beat1 ? w_laneMask[2*B-1:B] : w_laneMask[B-1:0];
  assign o_wdata        = i_beat1 ? (i_wdata >> w_highShift) : (i_wdata << w_lowShift);
  assign o_rdataAligned = i_beat1 ? (i_rdata << w_highShift) : (i_rdata >> w_lowShift);

  always_comb begin
    w_signBit = 1'b0;
    for (int i = 0; i < B; i++) begin
      if (i == int'(w_size) - 1) begin
        w_signBit = i_hold[8*i+7] & ~i_funct3[2];
      end
    end
  end

  always_comb begin
    o_loadExt = '0;
    for (int i = 0; i < B; i++) begin
      o_loadExt[8*i +: 8] = (i < int'(w_size)) ? i_hold[8*i +: 8] : {8{w_signBit}};
    end
  end

endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit: turns byte-addressed RV loads/stores into aligned memory beats.
// Define MEM_ALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they error.
module mem_align_unit
  import mem_align_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  mem_align_unit_if.slave io_bus
);
  localparam int B  = DATA_W / 8;
  localparam int LB = $clog2(B);
`ifdef MEM_ALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            r_state;
  state_e            w_nextState;
  logic              r_write;
  logic              r_err;
  funct3_e           r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hold;

  funct3_e           w_reqF3;
  logic [LB-1:0]     w_reqOff;
  logic [4:0]        w_reqEnd;
  logic [4:0]        w_curEnd;
  logic              w_reqCross;
  logic              w_curCross;
  logic              w_reqIllegal;
  logic              w_accept;
  logic              w_beatDone;
  logic              w_beat1;
  logic [ADDR_W-1:0] w_base;
  logic [DATA_W-1:0] w_laneWdata;
  logic [DATA_W-1:0] w_rdataAligned;
  logic [DATA_W-1:0] w_loadExt;
  logic [B-1:0]      w_laneBe;

  assign w_reqF3    = funct3_e'(io_bus.req_funct3);
  assign w_reqOff   = io_bus.req_addr[LB-1:0];
  assign w_reqEnd   = 5'(w_reqOff) + 5'(accessBytes(io_bus.req_funct3));
  assign w_reqCross = w_reqEnd > 5'(B);
  assign w_curEnd   = 5'(r_addr[LB-1:0]) + 5'(accessBytes(r_funct3));
  assign w_curCross = w_curEnd > 5'(B);

  always_comb begin
    w_reqIllegal = 1'b0;
    if (w_reqF3 == F3_RSVD) w_reqIllegal = 1'b1;
    if ((DATA_W == 32) && ((w_reqF3 == F3_D) || (w_reqF3 == F3_WU))) w_reqIllegal = 1'b1;
    if (io_bus.req_write && io_bus.req_funct3[2]) w_reqIllegal = 1'b1;
    if (w_reqCross && !SPLIT_EN) w_reqIllegal = 1'b1;
  end

  assign w_accept   = (r_state == S_IDLE) && rst && io_bus.req_valid;
  assign w_beatDone = ((r_state == S_BEAT0) || (r_state == S_BEAT1)) && io_bus.mem_resp;
  assign w_beat1    = (r_state == S_BEAT1);
  assign w_base     = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};

  mem_lane_shift #(.DATA_W(DATA_W)) u_laneShift (
    .i_funct3      (r_funct3),
    .i_off         (r_addr[LB-1:0]),
    .i_beat1       (w_beat1),
    .i_wdata       (r_wdata),
    .i_rdata       (io_bus.mem_rdata),
    .i_hold        (r_hold),
    .o_wdata       (w_laneWdata),
    .o_byteEnable  (w_laneBe),
    .o_rdataAligned(w_rdataAligned),
    .o_loadExt     (w_loadExt)
  );

  // Load bytes arrive right-justified from beat 0 and are OR-ed above them from beat 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= F3_B;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hold   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_write  <= io_bus.req_write;
        r_err    <= w_reqIllegal;
        r_funct3 <= w_reqF3;
        r_addr   <= io_bus.req_addr;
        r_wdata  <= io_bus.req_wdata;
        r_hold   <= '0;
      end else if (w_beatDone) begin
        r_hold <= w_beat1 ? (r_hold | w_rdataAligned) : w_rdataAligned;
      end
    end
  end

  always_comb begin
    w_nextState            = r_state;
    io_bus.req_ready       = 1'b0;
    io_bus.resp_valid      = 1'b0;
    io_bus.resp_err        = 1'b0;
    io_bus.resp_rdata      = '0;
    io_bus.mem_read        = 1'b0;
    io_bus.mem_write       = 1'b0;
    io_bus.mem_address     = '0;
    io_bus.mem_wdata       = '0;
    io_bus.mem_byte_enable = '0;
    case (r_state)
      S_IDLE: begin
        io_bus.req_ready = rst;
        if (rst && io_bus.req_valid) begin
          w_nextState = w_reqIllegal ? S_DONE : S_BEAT0;
        end
      end
      S_BEAT0, S_BEAT1: begin
        io_bus.mem_read        = ~r_write;
        io_bus.mem_write       = r_write;
        io_bus.mem_address     = w_beat1 ? (w_base + ADDR_W'(B)) : w_base;
        io_bus.mem_wdata       = w_laneWdata;
        io_bus.mem_byte_enable = w_laneBe;
        if (io_bus.mem_resp) begin
          w_nextState = (!w_beat1 && w_curCross) ? S_BEAT1 : S_DONE;
        end
      end
      S_DONE: begin
        io_bus.resp_valid = 1'b1;
        io_bus.resp_err   = r_err;
        io_bus.resp_rdata = (r_write || r_err) ? '0 : w_loadExt;
        w_nextState       = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit (DATA_W = 32) with a byte-level memory model
// and a randomly delayed memory responder; honours MEM_ALIGN_SPLIT_EN.
module tb_mem_align_unit;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        write;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic holdResp = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   finalRespEdge = 0;

  beat_t       beatQueue[$];
  logic [32:0] respQueue[$];
  logic [7:0]  memBytes [logic [31:0]];

  mem_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] readByte(input logic [31:0] a);
    if (memBytes.exists(a)) return memBytes[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] beMask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  function automatic logic isIllegal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'b111) return 1'b1;
    if (f3 == 3'b011 || f3 == 3'b110) return 1'b1;
    if (wr && f3[2]) return 1'b1;
`ifndef MEM_ALIGN_SPLIT_EN
    if (int'(addr[1:0]) + sz > 4) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = 1 << f3[1:0];
    if (sz > 4) sz = 4;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = readByte(addr + 32'(k));
    if (!f3[2] && v[8*sz-1]) begin
      for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // Each access byte k lands at addr+k; bytes past the first word form beat 1.
  task automatic buildBeats(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    beat_t b0, b1;
    logic [31:0] a;
    logic [31:0] base;
    logic used1;
    int sz;
    sz    = 1 << f3[1:0];
    base  = addr & ~32'h3;
    used1 = 1'b0;
    b0.addr = base;         b0.be = '0; b0.wdata = '0; b0.write = wr; b0.last = 1'b0;
    b1.addr = base + 32'h4; b1.be = '0; b1.wdata = '0; b1.write = wr; b1.last = 1'b1;
    for (int k = 0; k < sz; k++) begin
      a = addr + 32'(k);
      if ((a & ~32'h3) == base) begin
        b0.be[a[1:0]] = 1'b1;
        b0.wdata[8*int'(a[1:0]) +: 8] = wdata[8*k +: 8];
      end else begin
        used1 = 1'b1;
        b1.be[a[1:0]] = 1'b1;
        b1.wdata[8*int'(a[1:0]) +: 8] = wdata[8*k +: 8];
      end
    end
    b0.last = ~used1;
    beatQueue.push_back(b0);
    if (used1) beatQueue.push_back(b1);
  endtask

  initial begin
    beat_t expBeat;
    logic [69:0] snap;
    logic [31:0] rdata;
    int delay;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (rst && !holdResp && (bus.mem_read || bus.mem_write)) begin
        if (beatQueue.size() == 0) begin
          checkOutput("unexp_strobe", 1, 0);
          expBeat.addr = bus.mem_address; expBeat.be = bus.mem_byte_enable;
          expBeat.wdata = bus.mem_wdata;  expBeat.write = bus.mem_write; expBeat.last = 1'b1;
        end else begin
          expBeat = beatQueue.pop_front();
          checkOutput("beat_addr", bus.mem_address, expBeat.addr);
          checkOutput("beat_be", bus.mem_byte_enable, expBeat.be);
          checkOutput("beat_rw", {bus.mem_write, bus.mem_read}, {expBeat.write, ~expBeat.write});
          if (expBeat.write) begin
            checkOutput("beat_wdata", bus.mem_wdata & beMask(expBeat.be), expBeat.wdata);
          end
        end
        snap  = {bus.mem_address, bus.mem_byte_enable, bus.mem_wdata, bus.mem_read, bus.mem_write};
        delay = $urandom_range(0, 2);
        for (int d = 0; d < delay; d++) begin
          @(negedge clk);
          checkOutput("beat_stable",
                      {bus.mem_address, bus.mem_byte_enable, bus.mem_wdata, bus.mem_read, bus.mem_write}, snap);
        end
        if (bus.mem_write) begin
          for (int l = 0; l < 4; l++) begin
            if (bus.mem_byte_enable[l]) memBytes[bus.mem_address + 32'(l)] = bus.mem_wdata[8*l +: 8];
          end
          bus.mem_rdata = $urandom();
        end else begin
          for (int l = 0; l < 4; l++) rdata[8*l +: 8] = readByte(bus.mem_address + 32'(l));
          bus.mem_rdata = rdata;
        end
        bus.mem_resp = 1'b1;
        if (expBeat.last) finalRespEdge = cyc + 1;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData);
    logic expErr;
    logic [32:0] expResp;
    int acceptEdge;
    int w;
    expErr = isIllegal(wr, f3, addr);
    if (!expErr) buildBeats(wr, f3, addr, wdata);
    respQueue.push_back({expErr, (expErr || wr) ? 32'h0 : expData});
    @(negedge clk);
    checkOutput("ready_idle", bus.req_ready, 1);
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    acceptEdge = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    checkOutput("strobe_lat", bus.mem_read | bus.mem_write, !expErr);
    w = 0;
    while (!bus.resp_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    expResp = respQueue.pop_front();
    if (!bus.resp_valid) begin
      checkOutput("resp_timeout", 0, 1);
      beatQueue.delete();
    end else begin
      checkOutput("resp_lat", cyc, expErr ? acceptEdge : finalRespEdge);
      checkOutput("resp_err", bus.resp_err, expResp[32]);
      checkOutput("resp_rdata", bus.resp_rdata, expResp[31:0]);
      @(negedge clk);
      checkOutput("resp_pulse", bus.resp_valid, 0);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 0);
    checkOutput("rst_mem", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byte_enable}, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", bus.req_ready, 1);

    applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0);

    memBytes[32'h100] = 8'hFF; memBytes[32'h101] = 8'hFF;
    memBytes[32'h102] = 8'hFF; memBytes[32'h103] = 8'h80;
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080);

    memBytes[32'h1FC] = 8'h00; memBytes[32'h1FD] = 8'h00;
    memBytes[32'h1FE] = 8'h11; memBytes[32'h1FF] = 8'h22;
    memBytes[32'h200] = 8'h33; memBytes[32'h201] = 8'h44;
    memBytes[32'h202] = 8'h00; memBytes[32'h203] = 8'h00;
    applyStimulus(1'b0, 3'b010, 32'h1FE, 32'h0, 32'h44332211);

    applyStimulus(1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h202, 32'h0, 32'h00001234);

    memBytes[32'h204] = 8'h34; memBytes[32'h205] = 8'h92;
    applyStimulus(1'b0, 3'b001, 32'h204, 32'h0, 32'hFFFF9234);
    applyStimulus(1'b0, 3'b101, 32'h204, 32'h0, 32'h00009234);

    applyStimulus(1'b0, 3'b111, 32'h100, 32'h0, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 32'h0);

    applyStimulus(1'b1, 3'b000, 32'h101, 32'hAABBCCDD, 32'h0);
    applyStimulus(1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFDD);

    // Reset while beat 0 is outstanding must drop the strobe and yield no response.
    holdResp = 1'b1;
    @(negedge clk);
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rst_mid_read", bus.mem_read, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_drop", bus.mem_read, 0);
    checkOutput("rst_mid_ready", bus.req_ready, 0);
    checkOutput("rst_mid_resp", bus.resp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready_back", bus.req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_resp", bus.resp_valid, 0);
    end
    holdResp = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h300 + 32'($urandom_range(0, 31));
      wd   = $urandom();
      applyStimulus(wr, f3, addr, wd, (wr || isIllegal(wr, f3, addr)) ? 32'h0 : modelLoad(f3, addr));
    end

    checkOutput("beats_left", 96'(beatQueue.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
